// File: rtl/bht_ctrl_pkg.sv
// Shared types and constants for the branch history table controller.
// Holds FSM encodings, 2-bit counter values and the saturating counter update.
package bht_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  localparam logic [1:0] CNT_SNT  = 2'b00;
  localparam logic [1:0] CNT_WNT  = 2'b01;
  localparam logic [1:0] CNT_WT   = 2'b10;
  localparam logic [1:0] CNT_ST   = 2'b11;
  localparam logic [1:0] CNT_INIT = CNT_WNT;

  // Both weak states jump straight to the matching strong state.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    case (cnt)
      CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
      CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
      default: cnt_next = taken ? CNT_ST  : CNT_SNT;
    endcase
  endfunction

endpackage

// File: rtl/bht_ctrl_upd_fifo.sv
// Synchronous FIFO holding resolved-branch updates {idx, taken}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bht_upd_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rdata_o = mem_q[rptr_q[AW-1:0]];
    wptr_d  = (push_i && !full_o) ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = (pop_i && !empty_o) ? rptr_q + PTR_ONE : rptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: registered lookups, buffered updates, init sweep.
// Build option BHT_BYPASS_EN forwards a same-cycle drain write to a colliding lookup.
//
// Handshake: an update transfers on a rising clock edge where upd_valid and
// upd_ready are both high; upd_ready never depends on upd_valid.
module bht_ctrl
  import bht_ctrl_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int PC_LSB     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        upd_ready,
  output logic        busy,
  output logic        upd_pending,
  output bht_state_e  dbg_state
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       table_q [2**IDX_W];
  logic             pred_valid_q, pred_taken_q;

  logic [IDX_W-1:0] lookup_idx, upd_idx, head_idx, tbl_widx;
  logic [IDX_W:0]   fifo_rdata;
  logic             head_taken, fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             tbl_we, lookup_bit;
  logic [1:0]       tbl_wdata;
  logic             unused_pc_bits;

  assign lookup_idx = lookup_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign upd_idx    = upd_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign head_idx   = fifo_rdata[IDX_W:1];
  assign head_taken = fifo_rdata[0];
  assign unused_pc_bits = ^{lookup_pc[31:PC_LSB+IDX_W], lookup_pc[PC_LSB-1:0],
                            upd_pc[31:PC_LSB+IDX_W], upd_pc[PC_LSB-1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + IDX_ONE;
      if (ptr_q == IDX_MAX) state_d = RUN;
    end
  end

  // Single table write port: the sweep owns it in INIT, the drain in RUN.
  always_comb begin
    busy      = (state_q == INIT);
    upd_ready = (state_q == RUN) && !fifo_full;
    fifo_push = upd_valid && upd_ready;
    fifo_pop  = (state_q == RUN) && !fifo_empty;
    tbl_we    = 1'b0;
    tbl_widx  = ptr_q;
    tbl_wdata = CNT_INIT;
    if (state_q == INIT) begin
      tbl_we = 1'b1;
    end else if (fifo_pop) begin
      tbl_we    = 1'b1;
      tbl_widx  = head_idx;
      tbl_wdata = cnt_next(table_q[head_idx], head_taken);
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we) table_q[tbl_widx] <= tbl_wdata;
  end

  always_comb begin
`ifdef BHT_BYPASS_EN
    lookup_bit = (fifo_pop && (head_idx == lookup_idx)) ? tbl_wdata[1] : table_q[lookup_idx][1];
`else
    lookup_bit = table_q[lookup_idx][1];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= lookup_valid && (state_q == RUN);
      if (lookup_valid && (state_q == RUN)) pred_taken_q <= lookup_bit;
    end
  end

  bht_upd_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({upd_idx, upd_taken}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign upd_pending = !fifo_empty;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: sweep timing, counter updates, collisions, reset flush.
module tb_bht_ctrl;
  import bht_ctrl_pkg::*;

  localparam int IDX_W = 6;
  localparam int N     = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_valid, pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready, busy, upd_pending;
  bht_state_e  dbg_state;

  int          tests_run = 0;
  int          fails = 0;
  logic [0:0]  exp_q[$];
  logic [0:0]  exp_bit;
  logic [1:0]  mdl [N];

  // clock / reset
  always #5 clock = ~clock;

  bht_ctrl #(.IDX_W(IDX_W), .PC_LSB(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy), .upd_pending(upd_pending),
    .dbg_state(dbg_state)
  );

  // scoreboard: every prediction pops one expected direction
  always @(negedge clock) begin
    if (pred_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pred_unexpected: pred_valid=1 with no lookup outstanding");
      end else begin
        exp_bit = exp_q.pop_front();
        if (pred_taken !== exp_bit) begin
          fails++;
          $display("FAIL pred_taken: got %b expected %b at %0t", pred_taken, exp_bit, $time);
        end
      end
    end
  end

  function automatic logic [1:0] mdl_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b00) ? 2'b01 : 2'b11;
    return (c == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] idx_pc(input int idx);
    logic [31:0] pc;
    pc = ($urandom & 32'hFFFF_FF00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  // driver tasks (called right after a falling edge)
  task automatic lookup(input logic [31:0] pc, input logic exp);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    exp_q.push_back(exp);
    @(negedge clock);
    lookup_valid = 1'b0;
  endtask

  task automatic send_update(input int idx, input logic tk);
    int guard = 0;
    while (upd_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    tests_run++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL upd_ready_timeout: upd_ready=%b expected 1", upd_ready);
    end
    upd_valid = 1'b1;
    upd_pc    = idx_pc(idx);
    upd_taken = tk;
    mdl[idx]  = mdl_next(mdl[idx], tk);
    @(negedge clock);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests_run++;
    if (busy !== 1'b1 || upd_ready !== 1'b0 || upd_pending !== 1'b0 || pred_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b upd_ready=%b upd_pending=%b pred_valid=%b expected 1 0 0 0",
               busy, upd_ready, upd_pending, pred_valid);
    end
    reset = 1'b0;
    lookup_valid = 1'b1;
    for (int k = 1; k <= N; k++) begin
      lookup_pc = $urandom;
      @(negedge clock);
      tests_run++;
      if (busy !== (k < N) || upd_ready !== (k == N) || dbg_state !== ((k < N) ? INIT : RUN)) begin
        fails++;
        $display("FAIL sweep_cycle_%0d: busy=%b upd_ready=%b state=%b expected %b %b", k,
                 busy, upd_ready, dbg_state, (k < N), (k == N));
      end
    end
    lookup_valid = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = 2'b01;
    lookup(32'h0000_0100, 1'b0);
  endtask

  task automatic test_counter();
    send_update(16, 1'b1);
    @(negedge clock);
    lookup(32'h0000_0040, 1'b1);
    send_update(16, 1'b0);
    @(negedge clock);
    lookup(32'h0000_0040, 1'b1);
    send_update(16, 1'b0);
    @(negedge clock);
    lookup(32'h0000_0040, 1'b0);
  endtask

  task automatic test_collision();
    send_update(32, 1'b1);
`ifdef BHT_BYPASS_EN
    lookup(32'h0000_0080, 1'b1);
`else
    lookup(32'h0000_0080, 1'b0);
`endif
    @(negedge clock);
    lookup(32'h0000_0080, 1'b1);
  endtask

  task automatic test_back_to_back();
    int idx;
    logic tk;
    for (int i = 0; i < 14; i++) begin
      idx = (i < 2) ? 5 : $urandom_range(0, 3) * 8 + 1;
      tk  = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      tests_run++;
      if (upd_ready !== 1'b1 || (i > 0 && upd_pending !== 1'b1)) begin
        fails++;
        $display("FAIL b2b_flow_%0d: upd_ready=%b upd_pending=%b expected 1 1", i, upd_ready, upd_pending);
      end
      upd_valid = 1'b1;
      upd_pc    = idx_pc(idx);
      upd_taken = tk;
      mdl[idx]  = mdl_next(mdl[idx], tk);
      @(negedge clock);
    end
    upd_valid = 1'b0;
    @(negedge clock);
    tests_run++;
    if (upd_pending !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drained: upd_pending=%b expected 0", upd_pending);
    end
    for (int i = 0; i < N; i++) begin
      lookup_valid = 1'b1;
      lookup_pc    = idx_pc(i);
      exp_q.push_back(mdl[i][1]);
      @(negedge clock);
    end
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    upd_valid = 1'b1;
    upd_pc    = idx_pc(9);
    upd_taken = 1'b0;
    @(negedge clock);
    upd_valid = 1'b0;
    tests_run++;
    if (upd_pending !== 1'b1) begin
      fails++;
      $display("FAIL mid_pending: upd_pending=%b expected 1", upd_pending);
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (upd_pending !== 1'b0 || busy !== 1'b1 || upd_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: upd_pending=%b busy=%b upd_ready=%b expected 0 1 0",
               upd_pending, busy, upd_ready);
    end
    reset = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    tests_run++;
    if (cyc != N) begin
      fails++;
      $display("FAIL resweep_len: busy cycles=%0d expected %0d", cyc, N);
    end
    for (int i = 0; i < N; i++) mdl[i] = 2'b01;
    for (int i = 0; i < N; i++) begin
      lookup_valid = 1'b1;
      lookup_pc    = idx_pc(i);
      exp_q.push_back(1'b0);
      @(negedge clock);
    end
    lookup_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clock);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pred_missing: %0d predictions outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
